// File: rtl/countdown_timer_ctrl.sv
// Control FSM for the 4-digit countdown timer: owns the binary down-count,
// the stored limit and the alarm dwell, sequencing IDLE/RUN/PAUSE/DONE.
module countdown_timer_ctrl #(
  parameter int CNT_BITS      = 14,
  parameter int MAX_COUNT     = 9999,
  parameter int DEFAULT_LIMIT = 30,
  parameter int ALARM_TICKS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                btn_sp,
  input  logic                btn_load,
  input  logic [CNT_BITS-1:0] limit_in,
  output logic [CNT_BITS-1:0] count,
  output logic [1:0]          state,
  output logic                running,
  output logic                alarm
);

  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [CNT_BITS-1:0] MAX_C   = CNT_BITS'(MAX_COUNT);
  localparam logic [CNT_BITS-1:0] DEF_C   = CNT_BITS'(DEFAULT_LIMIT);
  localparam logic [CNT_BITS-1:0] ONE_C   = CNT_BITS'(1);
  localparam logic [AW-1:0]       ALARM_L = AW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              st;
  logic [CNT_BITS-1:0] limit_reg;
  logic [AW-1:0]       alarm_cnt;

  function automatic logic [CNT_BITS-1:0] sat_limit(input logic [CNT_BITS-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      count     <= DEF_C;
      limit_reg <= DEF_C;
      alarm_cnt <= '0;
      running   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (btn_load) begin
            limit_reg <= sat_limit(limit_in);
            count     <= sat_limit(limit_in);
          end else if (btn_sp) begin
            if (count != '0) begin
              st      <= RUN;
              running <= 1'b1;
            end else begin
              st        <= DONE;
              alarm     <= 1'b1;
              alarm_cnt <= '0;
            end
          end
        end
        RUN: begin
          if (btn_load) begin
            st      <= IDLE;
            running <= 1'b0;
            count   <= limit_reg;
          end else if (btn_sp) begin
            st      <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            // Final decrement and entry to DONE share one edge; never wrap below 0.
            if (count > ONE_C) begin
              count <= count - ONE_C;
            end else begin
              count     <= '0;
              st        <= DONE;
              running   <= 1'b0;
              alarm     <= 1'b1;
              alarm_cnt <= '0;
            end
          end
        end
        PAUSE: begin
          if (btn_load) begin
            st    <= IDLE;
            count <= limit_reg;
          end else if (btn_sp) begin
            st      <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          if (btn_load || btn_sp) begin
            st    <= IDLE;
            alarm <= 1'b0;
            count <= limit_reg;
          end else if (tick) begin
            alarm_cnt <= alarm_cnt + AW'(1);
            if (alarm_cnt == ALARM_L) begin
              st    <= IDLE;
              alarm <= 1'b0;
              count <= limit_reg;
            end
          end
        end
        default: begin
          st      <= IDLE;
          running <= 1'b0;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: a behavioural model predicts the
// outputs after each edge, a separate monitor pops and compares them.
module tb_countdown_timer_ctrl;

  localparam int CB = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          btn_sp = 1'b0;
  logic          btn_load = 1'b0;
  logic [CB-1:0] limit_in = '0;
  logic [CB-1:0] count;
  logic [1:0]    state;
  logic          running;
  logic          alarm;

  countdown_timer_ctrl #(
    .CNT_BITS(CB), .MAX_COUNT(9999), .DEFAULT_LIMIT(30), .ALARM_TICKS(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_sp(btn_sp), .btn_load(btn_load),
    .limit_in(limit_in), .count(count), .state(state), .running(running),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int cnt;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc_no = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause, 3 done.
  int m_mode = 0;
  int m_cnt  = 30;
  int m_lim  = 30;
  int m_dwell = 0;

  task automatic model_step(input bit r, input bit sp, input bit ld,
                            input bit tk, input int li);
    if (r) begin
      m_mode = 0; m_cnt = 30; m_lim = 30; m_dwell = 0;
    end else if (ld) begin
      if (m_mode == 0) begin
        m_lim = (li > 9999) ? 9999 : li;
        m_cnt = m_lim;
      end else begin
        m_mode = 0;
        m_cnt  = m_lim;
      end
    end else if (sp) begin
      if (m_mode == 0) begin
        m_mode  = (m_cnt != 0) ? 1 : 3;
        m_dwell = 0;
      end else if (m_mode == 1) m_mode = 2;
      else if (m_mode == 2) m_mode = 1;
      else begin
        m_mode = 0;
        m_cnt  = m_lim;
      end
    end else if (tk) begin
      if (m_mode == 1) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_mode  = 3;
          m_dwell = 0;
        end
      end else if (m_mode == 3) begin
        m_dwell++;
        if (m_dwell == 8) begin
          m_mode = 0;
          m_cnt  = m_lim;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit sp, input bit ld, input bit tk,
                     input int li);
    exp_t e;
    @(negedge clk);
    rst = r; btn_sp = sp; btn_load = ld; tick = tk; limit_in = CB'(li);
    model_step(r, sp, ld, tk, li);
    cyc_no++;
    e.st = m_mode; e.cnt = m_cnt; e.cyc = cyc_no;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0);
  endtask

  task automatic check(input string name, input int act, input int req, input int c);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, req);
  endtask

  // Monitor: outputs settle just after each edge; compare against the model.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("state",   int'(state),   e.st,             e.cyc);
        check("count",   int'(count),   e.cnt,            e.cyc);
        check("running", int'(running), int'(e.st == 1), e.cyc);
        check("alarm",   int'(alarm),   int'(e.st == 3), e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int li;
    // Full countdown from default, alarm dwell, auto-return.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(2);
    ticks(2);
    cyc(0, 1, 0, 0, 0);
    ticks(30);
    ticks(8);
    idle(2);
    // Saturated load, zero load, start from zero goes straight to DONE.
    cyc(0, 0, 1, 0, 12000);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(2);
    // Pause with simultaneous tick, ticks ignored in PAUSE, resume.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 5);
    cyc(0, 1, 0, 0, 0);
    ticks(2);
    cyc(0, 1, 0, 1, 0);
    ticks(4);
    cyc(0, 1, 0, 0, 0);
    ticks(1);
    // Abort during RUN keeps the old limit.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 5);
    cyc(0, 1, 0, 0, 0);
    ticks(1);
    cyc(0, 0, 1, 0, 77);
    idle(1);
    // DONE exited by start/pause, then by start+load together.
    cyc(0, 0, 1, 0, 2);
    cyc(0, 1, 0, 0, 0);
    ticks(2);
    ticks(3);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    ticks(2);
    ticks(3);
    cyc(0, 1, 1, 1, 500);
    idle(1);
    // Reset in the middle of RUN at count 17.
    cyc(0, 0, 1, 0, 20);
    cyc(0, 1, 0, 0, 0);
    ticks(3);
    cyc(1, 0, 0, 1, 0);
    idle(1);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      li = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383))
                                       : int'($urandom_range(0, 12));
      cyc(($urandom_range(0, 399) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 1) == 0),
          li);
    end
    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 0, cyc_no);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Control FSM for the lab's 4-digit countdown timer: owns the binary down-count register and sequences it through idle, run, pause and done. It turns one-pulse button inputs and a slow tick into count, load and alarm behaviour. The `count` output feeds the BCD conversion / 7-segment scan path, and `alarm` drives the LED bank.

## Interface

- `CNT_BITS`, 14, width of count and limit (4 decimal digits).
- `MAX_COUNT`, 9999, saturation ceiling for loaded limits.
- `DEFAULT_LIMIT`, 30, limit and count value after reset.
- `ALARM_TICKS`, 8, ticks spent in DONE before automatic return to IDLE; must be ≥1.

Ports:

- `clk`  in  1  system clock. One clock domain. Reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle count enable (e.g. 1 Hz pulse from the prescaler).
- `btn_sp`  in  1  start/pause request, already debounced and one-pulsed (high for exactly 1 cycle).
- `btn_load`  in  1  load/abort request, already debounced and one-pulsed.
- `limit_in`  in  CNT_BITS  new limit, sampled only on an accepted load.
- `count`  out  CNT_BITS  current remaining count.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `running`  out  1  high iff state==RUN.
- `alarm`  out  1  high iff state==DONE.

## Operation

- Internal registers: `limit_reg` (CNT_BITS), `alarm_cnt` (≥ clog2(ALARM_TICKS+1) bits).
- Reset values: state=IDLE, count=DEFAULT_LIMIT, limit_reg=DEFAULT_LIMIT, alarm_cnt=0, running=0, alarm=0.
- Reset overrides all other inputs in the same cycle.
- Load clamp: loaded value = min(limit_in, MAX_COUNT).
- IDLE:
  - `btn_load` → limit_reg and count ← clamped limit_in; stay in IDLE.
  - `btn_sp` → RUN if count≠0, else DONE.
  - `tick` is ignored.
- RUN:
  - `tick` with count>1 → count−1.
  - `tick` with count==1 → count=0 and DONE in the same edge.
  - `btn_sp` → PAUSE; a `tick` in that same cycle is dropped (count unchanged).
- PAUSE:
  - `tick` ignored, count held.
  - `btn_sp` → RUN. The first decrement happens on the next `tick` after the transition edge.
- DONE:
  - Entry clears alarm_cnt; count holds 0.
  - Each `tick` increments alarm_cnt.
  - On the tick that makes alarm_cnt==ALARM_TICKS → IDLE with count←limit_reg.
  - `btn_sp` → IDLE with count←limit_reg immediately.
- `btn_load` in RUN, PAUSE or DONE (abort) → IDLE with count←limit_reg. limit_in is not sampled and limit_reg is unchanged.
- Priority within one cycle: rst > btn_load > btn_sp > tick.
- Count never underflows. count==0 only in DONE, or in IDLE after loading 0.
- Decrement is plain binary subtract by 1 at CNT_BITS width. No BCD arithmetic in this block.

## Timing

- All outputs are registered and change only on `posedge clk`.
- `running` and `alarm` are decoded from the state register with no extra latency.
- Input pulse at cycle N → state/count update visible after edge N+1 (1-cycle latency).
- Every input is sampled every cycle. No handshake, no acknowledge. Multi-cycle-high buttons are treated as one request per high cycle (caller guarantees one-pulse).
- RUN to DONE occurs on the same edge as the final decrement. `alarm` rises in the cycle count first reads 0.
- Reset asserted mid-RUN/DONE → IDLE, DEFAULT_LIMIT on the next edge. Any prior `limit_reg` load is lost.

## Test plan

- Reset, then `btn_sp`, then 30 ticks:
  - count steps 30→29…→1→0.
  - state=DONE and alarm=1 on the edge after tick 30.
  - After 8 more ticks: state=IDLE, count=30, alarm=0.
- IDLE `btn_load` with limit_in=12000 → count=9999 and limit_reg=9999. Then `btn_load` with limit_in=0, then `btn_sp` → DONE directly, count=0.
- Load 5, start, 2 ticks (count=3), `btn_sp` together with a tick:
  - → PAUSE, count=3.
  - 4 ticks → count stays 3.
  - `btn_sp` → RUN; next tick → count=2.
- Load 5, start, 1 tick (count=4), `btn_load` with limit_in=77 → IDLE, count=5, limit_reg still 5 (limit_in ignored).
- In DONE after 3 ticks: `btn_sp` → IDLE, count=limit_reg. Repeat, but assert `btn_sp` and `btn_load` in the same cycle → IDLE via load path with identical result.
- Assert `rst` while RUN at count=17 → next edge: IDLE, count=30, alarm=0, running=0.
